// File: rtl/channel_select_ctrl.sv
// channel_select_ctrl
//
// Selects the ADC channel that the SPI ADC controller converts. The board
// DIP-switch address and the scan-enable switch are synchronised and
// debounced. A two-process FSM (MANUAL / SCAN / PEND) sends a new address
// to the SPI controller only while spi_busy is low.
//
// Optional auto-scan build macro: CHSEL_AUTOSCAN_EN
//   defined   : the SCAN state, the dwell counter, the scan_en debounce and
//               the scan_mask walk are built. In SCAN the channel moves
//               round-robin over scan_mask after DWELL_CONV conversions.
//   undefined : the FSM uses only MANUAL and PEND. scan_en, scan_mask and
//               conv_done are ignored, and scan_active stays 0.
//
// Handshake: spi_busy high means the SPI controller is mid-conversion.
// ch_addr_to_spi is held stable while it is high. ch_update pulses for one
// cycle on the cycle that ch_addr_to_spi takes a new value. No other
// handshake exists.
//
// Ports
//   clk, resetn     : clock and synchronous active-low reset
//   sw_addr         : raw DIP-switch channel address (asynchronous)
//   scan_en         : raw DIP switch that selects auto-scan (asynchronous)
//   scan_mask       : channels included in the scan (clk domain)
//   spi_busy        : SPI controller busy; the address must not change
//   conv_done       : one-cycle pulse for each completed conversion
//   ch_addr_to_spi  : active channel address
//   ch_update       : one-cycle pulse when ch_addr_to_spi changes
//   scan_active     : high in SCAN, or in PEND entered from SCAN
//   led             : one-hot indication of the active channel
//   state_dbg       : current FSM state encoding, for observation
module channel_select_ctrl #(
    parameter int NUM_CH     = 8,
    parameter int ADDR_W     = 3,
    parameter int DEB_CYCLES = 50000,
    parameter int DWELL_CONV = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic              scan_en,
    input  logic [NUM_CH-1:0] scan_mask,
    input  logic              spi_busy,
    input  logic              conv_done,
    output logic [ADDR_W-1:0] ch_addr_to_spi,
    output logic              ch_update,
    output logic              scan_active,
    output logic [NUM_CH-1:0] led,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_SCAN   = 2'd1,
        ST_PEND   = 2'd2
    } state_t;

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

    // ---------------- switch address: sync + debounce ----------------
    logic [ADDR_W-1:0] sw_s1_q, sw_s2_q;
    logic [ADDR_W-1:0] sw_cand_q, sw_cand_d;
    logic [DEB_W-1:0]  sw_cnt_q, sw_cnt_d;
    logic [ADDR_W-1:0] sw_stable_q, sw_stable_d;
    logic              sw_valid;

    // The counter saturates at DEB_MAX. The stable value is loaded on the
    // cycle the count reaches it, so the switch edge shows up in sw_stable
    // 2+DEB_CYCLES cycles later.
    always_comb begin
        sw_cand_d   = sw_cand_q;
        sw_cnt_d    = sw_cnt_q;
        sw_stable_d = sw_stable_q;
        if (sw_s2_q != sw_cand_q) begin
            sw_cand_d = sw_s2_q;
            sw_cnt_d  = '0;
        end else if (sw_cnt_q != DEB_MAX) begin
            sw_cnt_d = sw_cnt_q + DEB_W'(1);
        end
        if (sw_cnt_d == DEB_MAX) sw_stable_d = sw_cand_d;
    end

    // An address with no channel behind it is never taken as a target.
    assign sw_valid = (32'(sw_stable_q) < 32'(NUM_CH));

    // ---------------- FSM registers ----------------
    state_t            state_q, state_d;
    logic              origin_scan_q, origin_scan_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [ADDR_W-1:0] ch_addr_q, ch_addr_d;
    logic              ch_update_q, ch_update_d;
    logic              scan_active_q, scan_active_d;
    logic [NUM_CH-1:0] led_q, led_d;
    logic              scan_go;

`ifdef CHSEL_AUTOSCAN_EN
    localparam int DWELL_W = $clog2(DWELL_CONV + 1);

    logic              scan_s1_q, scan_s2_q;
    logic              scan_cand_q, scan_cand_d;
    logic [DEB_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic              scan_stable_q, scan_stable_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_inc;
    logic              next_found;
    logic [ADDR_W-1:0] next_ch;
    logic [NUM_CH-1:0] mask_rot;
    int                idx;

    always_comb begin
        scan_cand_d   = scan_cand_q;
        scan_cnt_d    = scan_cnt_q;
        scan_stable_d = scan_stable_q;
        if (scan_s2_q != scan_cand_q) begin
            scan_cand_d = scan_s2_q;
            scan_cnt_d  = '0;
        end else if (scan_cnt_q != DEB_MAX) begin
            scan_cnt_d = scan_cnt_q + DEB_W'(1);
        end
        if (scan_cnt_d == DEB_MAX) scan_stable_d = scan_cand_d;
    end

    assign scan_go   = scan_stable_q;
    assign dwell_inc = dwell_q + DWELL_W'(conv_done);

    // Find the first set mask bit above the current channel, wrapping
    // round to bit 0. The current channel is never a candidate.
    always_comb begin
        next_found = 1'b0;
        next_ch    = ch_addr_q;
        idx        = 0;
        mask_rot   = '0;
        for (int i = 1; i < NUM_CH; i++) begin
            idx      = (int'(ch_addr_q) + i) % NUM_CH;
            mask_rot = scan_mask >> ADDR_W'(idx);
            if (!next_found && mask_rot[0]) begin
                next_found = 1'b1;
                next_ch    = ADDR_W'(idx);
            end
        end
    end
`else
    logic unused_scan_inputs;
    assign unused_scan_inputs = ^{scan_en, scan_mask, conv_done};
    assign scan_go = 1'b0;
`endif

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        state_d       = state_q;
        origin_scan_d = origin_scan_q;
        target_d      = target_q;
        ch_addr_d     = ch_addr_q;
        ch_update_d   = 1'b0;
`ifdef CHSEL_AUTOSCAN_EN
        dwell_d       = dwell_q;
`endif
        case (state_q)
            ST_MANUAL: begin
                if (scan_go) begin
                    state_d = ST_SCAN;
`ifdef CHSEL_AUTOSCAN_EN
                    dwell_d = '0;
`endif
                end else if (sw_valid && (sw_stable_q != ch_addr_q)) begin
                    target_d      = sw_stable_q;
                    origin_scan_d = 1'b0;
                    state_d       = ST_PEND;
                end
            end
`ifdef CHSEL_AUTOSCAN_EN
            ST_SCAN: begin
                if (!scan_go) begin
                    state_d = ST_MANUAL;
                end else if (dwell_inc == DWELL_W'(DWELL_CONV)) begin
                    // The pulse on this cycle counts before the compare. The
                    // counter wraps even when no other channel is eligible.
                    dwell_d = '0;
                    if (next_found && (next_ch != ch_addr_q)) begin
                        target_d      = next_ch;
                        origin_scan_d = 1'b1;
                        state_d       = ST_PEND;
                    end
                end else begin
                    dwell_d = dwell_inc;
                end
            end
`endif
            ST_PEND: begin
                // A manual target follows the switch while we wait. The
                // latest value wins, and if it returns to the current
                // address we leave without a pulse.
                if (!origin_scan_q && sw_valid) target_d = sw_stable_q;
                if (!spi_busy) begin
                    if (target_d != ch_addr_q) begin
                        ch_addr_d   = target_d;
                        ch_update_d = 1'b1;
                    end
                    state_d = origin_scan_q ? ST_SCAN : ST_MANUAL;
                end
            end
            default: state_d = ST_MANUAL;
        endcase
        led_d         = NUM_CH'(1) << ch_addr_d;
        scan_active_d = (state_d == ST_SCAN) || ((state_d == ST_PEND) && origin_scan_d);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sw_s1_q       <= '0;
            sw_s2_q       <= '0;
            sw_cand_q     <= '0;
            sw_cnt_q      <= '0;
            sw_stable_q   <= '0;
            state_q       <= ST_MANUAL;
            origin_scan_q <= 1'b0;
            target_q      <= '0;
            ch_addr_q     <= '0;
            ch_update_q   <= 1'b0;
            scan_active_q <= 1'b0;
            led_q         <= NUM_CH'(1);
`ifdef CHSEL_AUTOSCAN_EN
            scan_s1_q     <= 1'b0;
            scan_s2_q     <= 1'b0;
            scan_cand_q   <= 1'b0;
            scan_cnt_q    <= '0;
            scan_stable_q <= 1'b0;
            dwell_q       <= '0;
`endif
        end else begin
            sw_s1_q       <= sw_addr;
            sw_s2_q       <= sw_s1_q;
            sw_cand_q     <= sw_cand_d;
            sw_cnt_q      <= sw_cnt_d;
            sw_stable_q   <= sw_stable_d;
            state_q       <= state_d;
            origin_scan_q <= origin_scan_d;
            target_q      <= target_d;
            ch_addr_q     <= ch_addr_d;
            ch_update_q   <= ch_update_d;
            scan_active_q <= scan_active_d;
            led_q         <= led_d;
`ifdef CHSEL_AUTOSCAN_EN
            scan_s1_q     <= scan_en;
            scan_s2_q     <= scan_s1_q;
            scan_cand_q   <= scan_cand_d;
            scan_cnt_q    <= scan_cnt_d;
            scan_stable_q <= scan_stable_d;
            dwell_q       <= dwell_d;
`endif
        end
    end

    assign ch_addr_to_spi = ch_addr_q;
    assign ch_update      = ch_update_q;
    assign scan_active    = scan_active_q;
    assign led            = led_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_channel_select_ctrl.sv
// Bench for channel_select_ctrl with NUM_CH=8, DEB_CYCLES=4, DWELL_CONV=3.
// The reference model works from the behavioural rules:
//   - each switch passes through a two-cycle delay;
//   - a value is accepted after it has been seen unchanged DEB times in a row;
//   - the channel moves only when the SPI controller is idle;
//   - in scan mode the channel walks the mask after DWELL conversions.
// The bench compares outputs after every clock edge.
module tb_channel_select_ctrl;
    localparam int NUM_CH = 8;
    localparam int ADDR_W = 3;
    localparam int DEB    = 4;
    localparam int DWELL  = 3;
`ifdef CHSEL_AUTOSCAN_EN
    localparam bit AUTOSCAN = 1'b1;
`else
    localparam bit AUTOSCAN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn;
    logic [ADDR_W-1:0] sw_addr;
    logic              scan_en;
    logic [NUM_CH-1:0] scan_mask;
    logic              spi_busy;
    logic              conv_done;
    logic [ADDR_W-1:0] ch_addr_to_spi;
    logic              ch_update;
    logic              scan_active;
    logic [NUM_CH-1:0] led;
    logic [1:0]        state_dbg;

    channel_select_ctrl #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DEB_CYCLES(DEB), .DWELL_CONV(DWELL)
    ) dut (
        .clk(clk), .resetn(resetn), .sw_addr(sw_addr), .scan_en(scan_en),
        .scan_mask(scan_mask), .spi_busy(spi_busy), .conv_done(conv_done),
        .ch_addr_to_spi(ch_addr_to_spi), .ch_update(ch_update),
        .scan_active(scan_active), .led(led), .state_dbg(state_dbg)
    );

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int upd_count = 0;
    int first_upd = -1;
    int base;
    bit sb_on = 1'b0;
    logic [ADDR_W-1:0] exp_q[$];

    // ---------------- reference model state ----------------
    logic [ADDR_W-1:0] m_s1, m_s2, m_last, m_stable;
    int                m_run;
    logic              m_e1, m_e2, m_elast, m_estable;
    int                m_erun;
    logic [ADDR_W-1:0] m_cur, m_target;
    bit                m_upd, m_pend, m_scan;
    int                m_dwell;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        logic [ADDR_W-1:0] t;
        int c;
        bit found;
        m_upd = 1'b0;
        t = m_cur;
        if (!resetn) begin
            m_s1 = '0; m_s2 = '0; m_last = '0; m_stable = '0; m_run = 0;
            m_e1 = 1'b0; m_e2 = 1'b0; m_elast = 1'b0; m_estable = 1'b0; m_erun = 0;
            m_cur = '0; m_target = '0; m_pend = 1'b0; m_scan = 1'b0; m_dwell = 0;
            return;
        end
        // Controller decisions use the accepted switch values from before this edge.
        if (m_pend) begin
            if (!m_scan && (int'(m_stable) < NUM_CH)) m_target = m_stable;
            if (!spi_busy) begin
                if (m_target != m_cur) begin
                    m_cur = m_target;
                    m_upd = 1'b1;
                end
                m_pend = 1'b0;
            end
        end else if (m_scan) begin
            if (!m_estable) begin
                m_scan = 1'b0;
            end else begin
                if (conv_done) m_dwell++;
                if (m_dwell == DWELL) begin
                    m_dwell = 0;
                    found = 1'b0;
                    for (int k = 1; k < NUM_CH; k++) begin
                        c = (int'(m_cur) + k) % NUM_CH;
                        if (!found && ((scan_mask >> c) & 8'd1) != 8'd0) begin
                            found = 1'b1;
                            t = ADDR_W'(c);
                        end
                    end
                    if (found) begin
                        m_target = t;
                        m_pend = 1'b1;
                    end
                end
            end
        end else begin
            if (AUTOSCAN && m_estable) begin
                m_scan = 1'b1;
                m_dwell = 0;
            end else if ((int'(m_stable) < NUM_CH) && (m_stable != m_cur)) begin
                m_target = m_stable;
                m_pend = 1'b1;
            end
        end
        // Debounce: accept a value seen DEB times in a row after the delay.
        if (m_s2 == m_last) m_run = (m_run < 1000) ? m_run + 1 : m_run;
        else begin m_last = m_s2; m_run = 1; end
        if (m_run >= DEB) m_stable = m_last;
        if (m_e2 == m_elast) m_erun = (m_erun < 1000) ? m_erun + 1 : m_erun;
        else begin m_elast = m_e2; m_erun = 1; end
        if (m_erun >= DEB) m_estable = m_elast;
        m_s2 = m_s1; m_s1 = sw_addr;
        m_e2 = m_e1; m_e1 = scan_en;
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic [ADDR_W-1:0] a, input logic se, input logic [NUM_CH-1:0] mk,
                        input logic busy, input logic cd, input logic rn);
        resetn = rn; sw_addr = a; scan_en = se; scan_mask = mk; spi_busy = busy; conv_done = cd;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check("ch_addr", 32'(ch_addr_to_spi), 32'(m_cur));
        check("ch_update", 32'(ch_update), 32'(m_upd));
        check("led", 32'(led), 32'(8'(1) << m_cur));
        check("scan_active", 32'(scan_active), 32'(m_scan));
        if (ch_update) begin
            upd_count++;
            if (first_upd < 0) first_upd = cyc;
            if (sb_on) begin
                if (exp_q.size() > 0) check("sb_ch", 32'(ch_addr_to_spi), 32'(exp_q.pop_front()));
                else check("sb_extra_update", 32'(ch_update), 32'd0);
            end
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic se;
        logic [NUM_CH-1:0] mk;
        logic [ADDR_W-1:0] a;
        int len;
        resetn = 1'b0; sw_addr = '0; scan_en = 1'b0; scan_mask = '0; spi_busy = 1'b0; conv_done = 1'b0;

        // Reset with the switch already at 5.
        for (int i = 0; i < 3; i++) step(3'd5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset_led", 32'(led), 32'h1);
        cyc = 0; upd_count = 0; first_upd = -1;

        // 1: power-up select of channel 5; exactly one pulse on cycle 2+4+1+1.
        for (int i = 0; i < 12; i++) step(3'd5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("t1_first_update_cycle", 32'(first_upd), 32'd8);
        check("t1_update_count", 32'(upd_count), 32'd1);
        check("t1_ch_addr", 32'(ch_addr_to_spi), 32'd5);
        check("t1_led", 32'(led), 32'h20);

        // 2: a two-cycle glitch is rejected.
        base = upd_count;
        for (int i = 0; i < 2; i++) step(3'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(3'd5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("t2_updates", 32'(upd_count - base), 32'd0);
        check("t2_ch_addr", 32'(ch_addr_to_spi), 32'd5);

        // 3: the change is held off while the SPI controller is busy.
        for (int i = 0; i < 20; i++) step(3'd6, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("t3_hold", 32'(ch_addr_to_spi), 32'd5);
        step(3'd6, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("t3_ch_addr", 32'(ch_addr_to_spi), 32'd6);
        check("t3_pulse", 32'(ch_update), 32'd1);
        for (int i = 0; i < 3; i++) step(3'd6, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Return to channel 0 before the scan tests.
        for (int i = 0; i < 12; i++) step(3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("ch0_before_scan", 32'(ch_addr_to_spi), 32'd0);

`ifdef CHSEL_AUTOSCAN_EN
        // 4: scan walks 0->2->7->0 over mask 1000_0101.
        for (int i = 0; i < 10; i++) step(3'd0, 1'b1, 8'h85, 1'b0, 1'b0, 1'b1);
        check("t4_scan_active", 32'(scan_active), 32'd1);
        exp_q.push_back(3'd2); exp_q.push_back(3'd7); exp_q.push_back(3'd0);
        sb_on = 1'b1;
        for (int p = 0; p < 9; p++) begin
            step(3'd0, 1'b1, 8'h85, 1'b0, 1'b1, 1'b1);
            for (int i = 0; i < 3; i++) step(3'd0, 1'b1, 8'h85, 1'b0, 1'b0, 1'b1);
        end
        sb_on = 1'b0;
        check("t4_sb_left", 32'(exp_q.size()), 32'd0);

        // 5: an empty mask keeps the channel; dropping scan_en returns to the switch.
        base = upd_count;
        for (int p = 0; p < 10; p++) begin
            step(3'd3, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
            for (int i = 0; i < 2; i++) step(3'd3, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        check("t5_no_updates", 32'(upd_count - base), 32'd0);
        for (int i = 0; i < 15; i++) step(3'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("t5_ch_addr", 32'(ch_addr_to_spi), 32'd3);
        check("t5_scan_off", 32'(scan_active), 32'd0);
        se = 1'b0;
`else
        // Without auto-scan the scan inputs have no effect.
        for (int p = 0; p < 10; p++) begin
            step(3'd0, 1'b1, 8'hff, 1'b0, 1'b1, 1'b1);
            for (int i = 0; i < 2; i++) step(3'd0, 1'b1, 8'hff, 1'b0, 1'b0, 1'b1);
        end
        check("ns_ch_addr", 32'(ch_addr_to_spi), 32'd0);
        check("ns_scan_active", 32'(scan_active), 32'd0);
        se = 1'b1;
`endif

        // 6: reset while a change is pending behind spi_busy.
        for (int i = 0; i < 12; i++) step(3'd4, se, 8'h00, 1'b1, 1'b0, 1'b1);
        step(3'd4, se, 8'h00, 1'b1, 1'b0, 1'b0);
        check("t6_ch_addr", 32'(ch_addr_to_spi), 32'd0);
        check("t6_led", 32'(led), 32'h1);
        check("t6_update", 32'(ch_update), 32'd0);
        check("t6_scan_active", 32'(scan_active), 32'd0);
        step(3'd4, se, 8'h00, 1'b0, 1'b0, 1'b0);

        // Randomised segments: varied hold times, busy, conversions and scan toggles.
        for (int s = 0; s < 70; s++) begin
            a   = ADDR_W'($urandom_range(0, NUM_CH - 1));
            mk  = NUM_CH'($urandom);
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 3) == 0) se = ~se;
            for (int j = 0; j < len; j++)
                step(a, se, mk, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
